// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the layer sequencer: FSM states, mode encodings
// and the mode/layer to pass-length mapping.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] MODE_A0    = 2'b00;
  localparam logic [1:0] MODE_A1    = 2'b01;
  localparam logic [1:0] MODE_B     = 2'b10;
  localparam logic [1:0] MODE_CHAIN = 2'b11;

  // Mode 3 runs LEN_A on layer 0 and LEN_B on layer 1.
  function automatic int pass_len(input logic [1:0] mode,
                                  input logic       layer,
                                  input int         len_a,
                                  input int         len_b);
    if (mode == MODE_B || (mode == MODE_CHAIN && layer)) begin
      return len_b;
    end
    return len_a;
  endfunction

endpackage

// File: rtl/nn_index_counter.sv
// Up-counter that wraps to 0 when it is advanced while sitting on its terminal
// value; clear has priority over enable.
module nn_index_counter #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [INDEX_WIDTH-1:0] terminal_i,
  output logic [INDEX_WIDTH-1:0] count_o,
  output logic                   is_terminal_o
);

  logic [INDEX_WIDTH-1:0] count_q, count_d;

  assign is_terminal_o = (count_q == terminal_i);
  assign count_o       = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = is_terminal_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences neuron/weight indices for one or two chained layer passes, with a
// downstream hold, per-layer last flag and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start_signal, ready_signal=1
// RUN   | presenting index/layer, advancing when hold_signal=0
// DONE  | one-cycle done_signal pulse, then IDLE
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int LEN_A       = 62,
  parameter int LEN_B       = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_signal,
  input  logic [1:0]             ctrl_data,
  input  logic                   hold_signal,
  output logic                   ready_signal,
  output logic                   busy_signal,
  output logic                   valid_signal,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   layer,
  output logic                   layer_last_signal,
  output logic                   done_signal
);

  if (LEN_A < 1 || LEN_B < 1 ||
      LEN_A > (1 << INDEX_WIDTH) || LEN_B > (1 << INDEX_WIDTH)) begin : g_bad_params
    $error("nn_layer_sequencer: LEN_A/LEN_B must be in 1..2**INDEX_WIDTH");
  end

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       layer_q, layer_d;

  logic                   cnt_clear;
  logic                   cnt_enable;
  logic                   cnt_terminal;
  logic [INDEX_WIDTH-1:0] terminal_value;
  logic [INDEX_WIDTH-1:0] count;

  assign terminal_value = INDEX_WIDTH'(pass_len(mode_q, layer_q, LEN_A, LEN_B) - 1);

  nn_index_counter #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (cnt_clear),
    .enable_i     (cnt_enable),
    .terminal_i   (terminal_value),
    .count_o      (count),
    .is_terminal_o(cnt_terminal)
  );

  // Start wins over everything except reset, so a start in RUN or DONE restarts.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    layer_d    = layer_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    if (start_signal) begin
      state_d   = RUN;
      mode_d    = ctrl_data;
      layer_d   = 1'b0;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (!hold_signal) begin
            cnt_enable = 1'b1;
            if (cnt_terminal) begin
              if (mode_q == MODE_CHAIN && !layer_q) begin
                layer_d = 1'b1;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_A0;
      layer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      layer_q <= layer_d;
    end
  end

  assign ready_signal      = (state_q == IDLE);
  assign busy_signal       = (state_q == RUN);
  assign valid_signal      = (state_q == RUN);
  assign index             = count;
  assign layer             = layer_q;
  assign layer_last_signal = (state_q == RUN) && cnt_terminal;
  assign done_signal       = (state_q == DONE);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: expected index/layer/last triples are
// queued at start and consumed by a monitor on each accepted index.
module tb_nn_layer_sequencer;

  localparam int IW = 8;
  localparam int LA = 62;
  localparam int LB = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_signal;
  logic [1:0]    ctrl_data;
  logic          hold_signal;
  logic          ready_signal;
  logic          busy_signal;
  logic          valid_signal;
  logic [IW-1:0] index;
  logic          layer;
  logic          layer_last_signal;
  logic          done_signal;

  typedef struct {
    int idx;
    bit lay;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .INDEX_WIDTH(IW),
    .LEN_A      (LA),
    .LEN_B      (LB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_signal     (start_signal),
    .ctrl_data        (ctrl_data),
    .hold_signal      (hold_signal),
    .ready_signal     (ready_signal),
    .busy_signal      (busy_signal),
    .valid_signal     (valid_signal),
    .index            (index),
    .layer            (layer),
    .layer_last_signal(layer_last_signal),
    .done_signal      (done_signal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_pass(input int len, input bit lay);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.idx  = i;
      e.lay  = lay;
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RUN cycle must match the head of the queue; pop when consumed.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid_signal === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("valid_with_nothing_expected", valid_signal, 0);
      end else begin
        check("index", index, exp_q[0].idx);
        check("layer", layer, exp_q[0].lay);
        check("layer_last", layer_last_signal, exp_q[0].last);
        if (hold_signal === 1'b0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_run(input logic [1:0] mode);
    start_signal = 1'b1;
    ctrl_data    = mode;
    case (mode)
      2'd2: push_pass(LB, 1'b0);
      2'd3: begin
        push_pass(LA, 1'b0);
        push_pass(LB, 1'b1);
      end
      default: push_pass(LA, 1'b0);
    endcase
    tick();
    start_signal = 1'b0;
  endtask

  // Called one cycle after the start edge; n counts cycles since that edge.
  task automatic wait_done(input string tag, input int exp_cycles, input int hold_at,
                           input int hold_len, input bit toggle);
    int n  = 1;
    int hc = 0;
    while (done_signal !== 1'b1 && n < 400) begin
      if (toggle) ctrl_data = 2'($urandom_range(0, 3));
      if (hc < hold_len && valid_signal === 1'b1 && int'(index) == hold_at) begin
        hold_signal = 1'b1;
        hc++;
      end else begin
        hold_signal = 1'b0;
      end
      tick();
      n++;
      if (hold_signal) check({tag, "_valid_while_held"}, valid_signal, 1);
    end
    hold_signal = 1'b0;
    check({tag, "_done_cycle"}, n, exp_cycles);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    rst          = 1'b1;
    start_signal = 1'b0;
    ctrl_data    = 2'd0;
    hold_signal  = 1'b0;
    repeat (3) tick();
    check("rst_ready", ready_signal, 1);
    check("rst_busy", busy_signal, 0);
    check("rst_valid", valid_signal, 0);
    check("rst_index", index, 0);
    check("rst_layer", layer, 0);
    check("rst_last", layer_last_signal, 0);
    check("rst_done", done_signal, 0);
    rst = 1'b0;
    tick();

    // Mode 0: 62 indices, done in cycle 63, ready in cycle 64.
    start_run(2'd0);
    wait_done("m0", LA + 1, 0, 0, 1'b0);
    tick();
    check("m0_ready_after_done", ready_signal, 1);
    check("m0_done_one_cycle", done_signal, 0);

    // Mode 2 with 3 stall cycles at index 5.
    start_run(2'd2);
    wait_done("m2_hold", LB + 1 + 3, 5, 3, 1'b0);
    tick();
    check("m2_ready_after_done", ready_signal, 1);

    // Mode 3 chained, ctrl_data toggling throughout; then start in the DONE cycle.
    start_run(2'd3);
    wait_done("m3", LA + LB + 1, 0, 0, 1'b1);
    start_run(2'd2);
    check("start_in_done_busy", busy_signal, 1);
    check("start_in_done_index", index, 0);
    check("start_in_done_layer", layer, 0);
    wait_done("after_done", LB + 1, 0, 0, 1'b1);
    tick();

    // Restart mid-run at index 30 with mode 2.
    start_run(2'd0);
    for (int k = 0; k < 100 && !(valid_signal === 1'b1 && index == 30); k++) tick();
    check("restart_reached_30", index, 30);
    start_signal = 1'b1;
    ctrl_data    = 2'd2;
    exp_q.delete();
    begin
      exp_t e;
      e.idx  = 30;
      e.lay  = 1'b0;
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    push_pass(LB, 1'b0);
    tick();
    start_signal = 1'b0;
    check("restart_index", index, 0);
    check("restart_busy", busy_signal, 1);
    wait_done("restart", LB + 1, 0, 0, 1'b0);
    tick();

    // Reset at index 10 together with start: reset wins.
    start_run(2'd1);
    for (int k = 0; k < 100 && !(valid_signal === 1'b1 && index == 10); k++) tick();
    check("rst_mid_reached_10", index, 10);
    rst          = 1'b1;
    start_signal = 1'b1;
    tick();
    rst          = 1'b0;
    start_signal = 1'b0;
    exp_q.delete();
    check("rst_mid_ready", ready_signal, 1);
    check("rst_mid_busy", busy_signal, 0);
    check("rst_mid_index", index, 0);
    check("rst_mid_layer", layer, 0);
    tick();
    check("rst_mid_stays_idle", ready_signal, 1);
    check("rst_mid_no_done", done_signal, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Parametrised successor to the single-pass neural-network index controller.
- Sequences neuron/weight indices for one or two chained layer passes, with per-mode lengths set by parameters.
- Adds a downstream hold handshake, a layer output, a per-layer last flag and a one-cycle done pulse.
- Sits between the top-level start logic and the datapath's weight/input memories; `index` addresses those memories directly.

Parameters:
- INDEX_WIDTH, 8: width of `index`; must satisfy 2**INDEX_WIDTH >= max(LEN_A, LEN_B).
- LEN_A, 62: pass length for modes 0 and 1, and for layer 0 of mode 3; must be >= 1.
- LEN_B, 20: pass length for mode 2, and for layer 1 of mode 3; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start_signal  input  1  begin (or restart) a sequence; sampled every cycle
- ctrl_data  input  2  mode select, sampled only on the cycle start_signal=1
- hold_signal  input  1  downstream stall; 1 = current index not consumed
- ready_signal  output  1  1 in IDLE only
- busy_signal  output  1  1 in RUN only
- valid_signal  output  1  `index`/`layer` are meaningful (equals RUN)
- index  output  INDEX_WIDTH  current index within the active layer pass
- layer  output  1  active layer: 0, or 1 for the second pass of mode 3
- layer_last_signal  output  1  valid_signal and index == current pass length-1
- done_signal  output  1  one-cycle pulse in DONE

Behaviour:
- States: IDLE, RUN, DONE. All state, index, layer and the latched mode are registers; outputs decode from them.
- Reset (rst=1 at a clk edge, highest priority, including mid-run):
  - next state IDLE; index=0, layer=0, latched mode=0.
  - ready_signal=1; busy/valid/layer_last/done = 0.
- Mode map:
  - 0 -> one pass of LEN_A.
  - 1 -> one pass of LEN_A.
  - 2 -> one pass of LEN_B.
  - 3 -> layer 0 pass of LEN_A, then layer 1 pass of LEN_B, with no gap cycle between them.
- Start:
  - start_signal=1 in any state (without rst) -> next cycle RUN, index=0, layer=0, mode latched from ctrl_data.
  - In RUN this is a restart: the current progress is discarded.
  - start_signal is level-sampled; holding it high keeps restarting at index 0.
- RUN advance:
  - Index is consumed on cycles with valid_signal=1 and hold_signal=0.
  - Not last: index increments by 1.
  - Last and the pass is the final one: next state DONE, index returns to 0.
  - Last in layer 0 of mode 3: index becomes 0, layer becomes 1, state stays RUN.
  - hold_signal=1: index, layer and state all hold; valid_signal stays 1.
- DONE: lasts exactly one cycle with done_signal=1, then IDLE. start_signal in DONE goes to RUN, not IDLE.
- IDLE: ctrl_data and hold_signal are ignored. Mode changes during RUN are ignored.
- Latency with no holds:
  - start sampled at edge 0 -> RUN first visible after edge 0.
  - Mode 0: done_signal high in the 63rd cycle after start, ready_signal back in the 64th.
  - Mode 3: done_signal in cycle 83.
- Width rules:
  - index compares against length-1 at INDEX_WIDTH bits; it never wraps past length-1.
  - LEN=1: layer_last_signal=1 on the first RUN cycle.
- Elaboration checks: LEN_A or LEN_B equal to 0, or exceeding 2**INDEX_WIDTH, is an elaboration error.

Decomposition:
- Package nn_ctrl_pkg holds:
  - state enum: IDLE, RUN, DONE.
  - mode encodings: MODE_A0=2'b00, MODE_A1=2'b01, MODE_B=2'b10, MODE_CHAIN=2'b11.
  - function pass_len(mode, layer) returning the pass length.
- One sub-module, nn_index_counter (parametrised by INDEX_WIDTH):
  - inputs: clear, enable, terminal value.
  - outputs: count and an is_terminal flag.
- nn_layer_sequencer owns the FSM, the mode latch and the layer bit.

Test Plan:
- Reset, then start with ctrl_data=0 and hold=0:
  - index 0..61 on consecutive cycles, layer_last_signal at index 61.
  - done_signal one cycle later, then ready_signal=1.
- Mode 2, hold_signal=1 for 3 cycles at index 5:
  - index stays 5 for those cycles with valid_signal=1.
  - sequence then continues 6..19; done arrives 3 cycles later than the unstalled case.
- Mode 3:
  - layer=0 with index 0..61, then immediately layer=1 with index 0..19.
  - single done_signal after layer 1 index 19; total of 82 RUN cycles.
- Restart mid-run:
  - mode 0 at index 30, then start_signal with ctrl_data=2.
  - next cycle index=0, layer=0, pass length 20; no done_signal from the aborted run.
- rst asserted at index 10 while start_signal=1 on the same cycle:
  - next cycle IDLE, ready_signal=1, index=0; rst wins.
- ctrl_data toggled during RUN, and start_signal asserted in the DONE cycle:
  - the toggle has no effect on pass length.
  - start in DONE goes directly to RUN with index=0.
